// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: turns decisecond ticks from the pacer into a BCD M:SS.t
// count and runs the IDLE/RUN/PAUSE/LAP state machine from button pulses.
// All outputs come straight from registers.
module stopwatch_controller #(
    parameter int MAX_MINUTES = 59
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       decisecond,
    input  logic       startStop,
    input  logic       lapSplit,
    input  logic       clear,
    output logic       pacerReStart,
    output logic [3:0] dispTenths,
    output logic [3:0] dispSecOnes,
    output logic [3:0] dispSecTens,
    output logic [3:0] dispMinOnes,
    output logic [3:0] dispMinTens,
    output logic       running,
    output logic       lapHeld,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
        logic [3:0] tenths;
    } bcd_time_t;

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);

    state_t    state_reg;
    bcd_time_t live_reg;
    bcd_time_t disp_reg;
    logic      pacer_reg;
    logic      running_reg;
    logic      lap_held_reg;
    logic      overflow_reg;

    bcd_time_t live_inc;
    bcd_time_t live_next;
    logic      at_max;
    logic      tick_counts;
    logic      wrap_now;

    // Next BCD value of the live count for one tick, with ripple carries and wrap at the maximum
    always_comb begin
        live_inc = live_reg;
        at_max   = (live_reg.min_tens == MAX_MIN_TENS) && (live_reg.min_ones == MAX_MIN_ONES) &&
                   (live_reg.sec_tens == 4'd5) && (live_reg.sec_ones == 4'd9) &&
                   (live_reg.tenths == 4'd9);
        if (at_max) begin
            live_inc = '0;
        end else if (live_reg.tenths != 4'd9) begin
            live_inc.tenths = live_reg.tenths + 4'd1;
        end else begin
            live_inc.tenths = 4'd0;
            if (live_reg.sec_ones != 4'd9) begin
                live_inc.sec_ones = live_reg.sec_ones + 4'd1;
            end else begin
                live_inc.sec_ones = 4'd0;
                if (live_reg.sec_tens != 4'd5) begin
                    live_inc.sec_tens = live_reg.sec_tens + 4'd1;
                end else begin
                    live_inc.sec_tens = 4'd0;
                    if (live_reg.min_ones != 4'd9) begin
                        live_inc.min_ones = live_reg.min_ones + 4'd1;
                    end else begin
                        live_inc.min_ones = 4'd0;
                        live_inc.min_tens = (live_reg.min_tens == 4'd9) ? 4'd0 : live_reg.min_tens + 4'd1;
                    end
                end
            end
        end
        // Ticks only count while the clock is running; a start in the same cycle
        // comes from IDLE/PAUSE, so that tick is dropped while the pacer restarts.
        tick_counts = decisecond && ((state_reg == RUN) || (state_reg == LAP));
        live_next   = tick_counts ? live_inc : live_reg;
        wrap_now    = tick_counts && at_max;
    end

    // State machine, live count, display snapshot and status flags
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg    <= IDLE;
            live_reg     <= '0;
            disp_reg     <= '0;
            pacer_reg    <= 1'b0;
            running_reg  <= 1'b0;
            lap_held_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            pacer_reg <= 1'b0;
            if (clear) begin
                state_reg    <= IDLE;
                live_reg     <= '0;
                disp_reg     <= '0;
                running_reg  <= 1'b0;
                lap_held_reg <= 1'b0;
                overflow_reg <= 1'b0;
            end else begin
                live_reg <= live_next;
                if (wrap_now) begin
                    overflow_reg <= 1'b1;
                end
                // Display follows the live count unless a lap hold stays in force
                disp_reg <= live_next;
                case (state_reg)
                    IDLE: begin
                        if (startStop) begin
                            state_reg   <= RUN;
                            pacer_reg   <= 1'b1;
                            running_reg <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (startStop) begin
                            state_reg   <= PAUSE;
                            running_reg <= 1'b0;
                        end else if (lapSplit) begin
                            state_reg    <= LAP;
                            lap_held_reg <= 1'b1;
                        end
                    end
                    LAP: begin
                        if (startStop) begin
                            state_reg    <= PAUSE;
                            running_reg  <= 1'b0;
                            lap_held_reg <= 1'b0;
                        end else if (lapSplit) begin
                            state_reg    <= RUN;
                            lap_held_reg <= 1'b0;
                        end else begin
                            disp_reg <= disp_reg;
                        end
                    end
                    PAUSE: begin
                        if (startStop) begin
                            state_reg   <= RUN;
                            pacer_reg   <= 1'b1;
                            running_reg <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pacerReStart = pacer_reg;
    assign dispTenths   = disp_reg.tenths;
    assign dispSecOnes  = disp_reg.sec_ones;
    assign dispSecTens  = disp_reg.sec_tens;
    assign dispMinOnes  = disp_reg.min_ones;
    assign dispMinTens  = disp_reg.min_tens;
    assign running      = running_reg;
    assign lapHeld      = lap_held_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor on the falling
// edge pops and compares them against the DUT outputs.
module tb_stopwatch_controller;

    logic       clk;
    logic       resetN;
    logic       decisecond;
    logic       startStop;
    logic       lapSplit;
    logic       clear;
    logic       pacerReStart;
    logic [3:0] dispTenths;
    logic [3:0] dispSecOnes;
    logic [3:0] dispSecTens;
    logic [3:0] dispMinOnes;
    logic [3:0] dispMinTens;
    logic       running;
    logic       lapHeld;
    logic       overflow;

    stopwatch_controller #(.MAX_MINUTES(1)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .decisecond   (decisecond),
        .startStop    (startStop),
        .lapSplit     (lapSplit),
        .clear        (clear),
        .pacerReStart (pacerReStart),
        .dispTenths   (dispTenths),
        .dispSecOnes  (dispSecOnes),
        .dispSecTens  (dispSecTens),
        .dispMinOnes  (dispMinOnes),
        .dispMinTens  (dispMinTens),
        .running      (running),
        .lapHeld      (lapHeld),
        .overflow     (overflow)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [19:0] disp;
        logic       run;
        logic       lap;
        logic       ovf;
        logic       pace;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: compare every expectation that has come due
    always @(negedge clk) begin
        logic [19:0] got;
        got = {dispMinTens, dispMinOnes, dispSecTens, dispSecOnes, dispTenths};
        while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            mon_e = q.pop_front();
            checks++;
            if (mon_e.cyc != cyc_cnt || got !== mon_e.disp || running !== mon_e.run ||
                lapHeld !== mon_e.lap || overflow !== mon_e.ovf || pacerReStart !== mon_e.pace) begin
                errors++;
                $display("FAIL %s: got disp=%h run=%b lap=%b ovf=%b pace=%b, want disp=%h run=%b lap=%b ovf=%b pace=%b (cyc %0d/%0d)",
                         mon_e.name, got, running, lapHeld, overflow, pacerReStart,
                         mon_e.disp, mon_e.run, mon_e.lap, mon_e.ovf, mon_e.pace, cyc_cnt, mon_e.cyc);
            end else begin
                $display("check %s ok: disp=%h run=%b lap=%b ovf=%b pace=%b",
                         mon_e.name, got, running, lapHeld, overflow, pacerReStart);
            end
        end
    end

    task automatic drive(input bit ss, input bit lp, input bit clr, input bit tick);
        @(negedge clk);
        startStop  = ss;
        lapSplit   = lp;
        clear      = clr;
        decisecond = tick;
    endtask

    task automatic push_at(input string nm, input int cyc, input logic [19:0] d,
                           input bit run, input bit lap, input bit ovf, input bit pace);
        exp_t e;
        e.name = nm;
        e.cyc  = cyc;
        e.disp = d;
        e.run  = run;
        e.lap  = lap;
        e.ovf  = ovf;
        e.pace = pace;
        q.push_back(e);
    endtask

    // Expectation for the cycle following the inputs just driven
    task automatic push_exp(input string nm, input logic [19:0] d,
                            input bit run, input bit lap, input bit ovf, input bit pace);
        push_at(nm, cyc_cnt + 1, d, run, lap, ovf, pace);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
    endtask

    initial begin
        resetN = 1'b0; decisecond = 1'b0; startStop = 1'b0; lapSplit = 1'b0; clear = 1'b0;

        drive(0, 0, 0, 0); push_exp("reset", 20'h00000, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1;

        // Start and count one second
        drive(1, 0, 0, 0); push_exp("start", 20'h00000, 1, 0, 0, 1);
        drive(0, 0, 0, 1); push_exp("first tick", 20'h00001, 1, 0, 0, 0);
        run_ticks(8);
        drive(0, 0, 0, 1); push_exp("ten ticks", 20'h00010, 1, 0, 0, 0);

        // Lap freeze and release
        run_ticks(24);
        drive(0, 1, 0, 0); push_exp("lap at 3.4", 20'h00034, 1, 1, 0, 0);
        run_ticks(4);
        drive(0, 0, 0, 1); push_exp("lap holds", 20'h00034, 1, 1, 0, 0);
        drive(0, 1, 0, 0); push_exp("lap release", 20'h00039, 1, 0, 0, 0);
        drive(0, 1, 0, 1); push_exp("tick+lap", 20'h00040, 1, 1, 0, 0);
        drive(0, 0, 0, 1); push_exp("lap live adv", 20'h00040, 1, 1, 0, 0);
        drive(1, 0, 0, 0); push_exp("lap to pause", 20'h00041, 0, 0, 0, 0);
        drive(0, 1, 0, 0); push_exp("pause lap ign", 20'h00041, 0, 0, 0, 0);
        drive(1, 0, 0, 0); push_exp("resume 4.1", 20'h00041, 1, 0, 0, 1);

        // Pause holds the count
        drive(0, 0, 1, 0); push_exp("clear", 20'h00000, 0, 0, 0, 0);
        drive(1, 0, 0, 0); push_exp("restart", 20'h00000, 1, 0, 0, 1);
        run_ticks(19);
        drive(0, 0, 0, 1); push_exp("at 2.0", 20'h00020, 1, 0, 0, 0);
        drive(1, 0, 0, 0); push_exp("pause", 20'h00020, 0, 0, 0, 0);
        run_ticks(6);
        drive(0, 0, 0, 1); push_exp("pause ticks ign", 20'h00020, 0, 0, 0, 0);
        drive(1, 0, 0, 0); push_exp("resume 2.0", 20'h00020, 1, 0, 0, 1);
        drive(0, 0, 0, 1); push_exp("resume tick", 20'h00021, 1, 0, 0, 0);

        // Same-cycle tick with start/stop
        drive(0, 0, 1, 0); push_exp("clear 2", 20'h00000, 0, 0, 0, 0);
        drive(1, 0, 0, 0); push_exp("start 3", 20'h00000, 1, 0, 0, 1);
        run_ticks(5);
        drive(1, 0, 0, 1); push_exp("tick+stop", 20'h00006, 0, 0, 0, 0);
        drive(1, 0, 0, 1); push_exp("tick+start", 20'h00006, 1, 0, 0, 1);

        // Minute carry and wrap (MAX_MINUTES = 1)
        run_ticks(592);
        drive(0, 0, 0, 1); push_exp("at 0:59.9", 20'h00599, 1, 0, 0, 0);
        drive(0, 0, 0, 1); push_exp("min carry", 20'h01000, 1, 0, 0, 0);
        run_ticks(598);
        drive(0, 0, 0, 1); push_exp("at 1:59.9", 20'h01599, 1, 0, 0, 0);
        drive(0, 0, 0, 1); push_exp("wrap", 20'h00000, 1, 0, 1, 0);
        drive(0, 0, 0, 1); push_exp("ovf sticky", 20'h00001, 1, 0, 1, 0);
        drive(0, 0, 1, 1); push_exp("tick+clear", 20'h00000, 0, 0, 0, 0);
        drive(0, 1, 0, 0); push_exp("idle lap ign", 20'h00000, 0, 0, 0, 0);
        drive(0, 0, 0, 1); push_exp("idle tick ign", 20'h00000, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        drive(1, 0, 0, 0); push_exp("start 4", 20'h00000, 1, 0, 0, 1);
        run_ticks(122);
        drive(0, 0, 0, 1); push_exp("at 12.3", 20'h00123, 1, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        push_at("async reset", cyc_cnt, 20'h00000, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        drive(0, 0, 0, 1); push_exp("post reset tick", 20'h00000, 0, 0, 0, 0);
        drive(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
